data_demultiplexer: RTL and testbench

- Packet-granular stream router: takes one ndata input stream and steers each whole packet (up to and including the `last` beat) to one of NUM_STREAMS outputs.
- Destination is chosen by an index consumed from a ready/valid select stream, one index per packet.
- Counterpart of the stream multiplexer: fan-out stage in the stream fabric, in front of per-lane consumers.

---
 rtl/data_demultiplexer_pkg.sv | 14 +
 rtl/data_demultiplexer_packet_counter.sv | 28 ++
 rtl/data_demultiplexer.sv | 109 ++++++++++
 tb/tb_data_demultiplexer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_demultiplexer_pkg.sv
// Shared stream-fabric definitions: demux/arbiter state encoding and select-width helper.
package data_demultiplexer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } demux_state_e;

  // Always at least one bit, so a degenerate stream count still yields a legal vector.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_demultiplexer_packet_counter.sv
// Free-running event counter that wraps modulo 2^WIDTH; exists only when
// DATA_DEMULTIPLEXER_STATS_EN is defined.
`ifdef DATA_DEMULTIPLEXER_STATS_EN
module packet_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/data_demultiplexer.sv
// Packet-granular stream demultiplexer: one select index per packet steers all beats
// up to `last` to one output. Optional per-output statistics: DATA_DEMULTIPLEXER_STATS_EN.
module data_demultiplexer
  import data_demultiplexer_pkg::*;
#(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 1,
  parameter int  NUM_STREAMS  = 2,
  localparam int SEL_W        = sel_width(NUM_STREAMS)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
`ifdef DATA_DEMULTIPLEXER_STATS_EN
  output logic [NUM_STREAMS-1:0][31:0]              pkt_count_o,
  output logic [31:0]                               drop_count_o,
`endif
  input  logic                                      select_valid_i,
  input  logic [SEL_W-1:0]                          select_data_i,
  output logic                                      select_ready_o,
  input  logic                                      in_valid_i,
  input  data_t [NUM_ELEMENTS-1:0]                  in_data_i,
  input  logic  [NUM_ELEMENTS-1:0]                  in_keep_i,
  input  logic                                      in_last_i,
  output logic                                      in_ready_o,
  output logic  [NUM_STREAMS-1:0]                   out_valid_o,
  output data_t [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] out_data_o,
  output logic  [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] out_keep_o,
  output logic  [NUM_STREAMS-1:0]                   out_last_o,
  input  logic  [NUM_STREAMS-1:0]                   out_ready_i
);

  demux_state_e     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             drop_q, drop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
    end
  end

  // Handshakes are gated by rst_n so nothing is offered or accepted while reset is held.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    drop_d         = drop_q;
    select_ready_o = 1'b0;
    in_ready_o     = 1'b0;
    out_valid_o    = '0;
    out_data_o     = 'x;
    out_keep_o     = 'x;
    out_last_o     = 'x;
    unique case (state_q)
      IDLE: begin
        select_ready_o = rst_n;
        if (select_valid_i && rst_n) begin
          sel_d   = select_data_i;
          drop_d  = ({1'b0, select_data_i} >= (SEL_W + 1)'(NUM_STREAMS));
          state_d = ROUTE;
        end
      end
      ROUTE: begin
        if (drop_q) begin
          in_ready_o = rst_n;
        end else begin
          for (int i = 0; i < NUM_STREAMS; i++) begin
            if (sel_q == SEL_W'(i)) begin
              out_valid_o[i] = in_valid_i & rst_n;
              out_data_o[i]  = in_data_i;
              out_keep_o[i]  = in_keep_i;
              out_last_o[i]  = in_last_i;
              in_ready_o     = out_ready_i[i] & rst_n;
            end
          end
        end
        if (in_valid_i && in_ready_o && in_last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DATA_DEMULTIPLEXER_STATS_EN
  logic pktDone;
  assign pktDone = (state_q == ROUTE) && in_valid_i && in_ready_o && in_last_i;

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : gen_pkt_cnt
    packet_counter #(.WIDTH(32)) u_pkt_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (pktDone && !drop_q && (sel_q == SEL_W'(g))),
      .count_o (pkt_count_o[g])
    );
  end

  packet_counter #(.WIDTH(32)) u_drop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (pktDone && drop_q),
    .count_o (drop_count_o)
  );
`endif

endmodule

// File: tb/tb_data_demultiplexer.sv
// Directed, table-driven bench for data_demultiplexer: a 4-output instance for routing,
// backpressure and reset, plus a 3-output instance for out-of-range (dropped) packets.
module tb_data_demultiplexer;

  typedef struct packed {
    logic        rstN;
    logic        selValid;
    logic [1:0]  selData;
    logic        inValid;
    logic [15:0] inData;
    logic [1:0]  inKeep;
    logic        inLast;
    logic [3:0]  outReady;
    logic        expSelReady;
    logic        expInReady;
    logic [3:0]  expValid;
    logic [15:0] expData;
    logic [1:0]  expKeep;
    logic        expLast;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-output instance
  logic                 selValid = 1'b0;
  logic [1:0]           selData = '0;
  logic                 selReady;
  logic                 inValid = 1'b0;
  logic [1:0][7:0]      inData = '0;
  logic [1:0]           inKeep = '0;
  logic                 inLast = 1'b0;
  logic                 inReady;
  logic [3:0]           outValid;
  logic [3:0][1:0][7:0] outData;
  logic [3:0][1:0]      outKeep;
  logic [3:0]           outLast;
  logic [3:0]           outReady = '1;

  // 3-output instance
  logic                 s3SelValid = 1'b0;
  logic [1:0]           s3SelData = '0;
  logic                 s3SelReady;
  logic                 s3InValid = 1'b0;
  logic [1:0][7:0]      s3InData = '0;
  logic [1:0]           s3InKeep = '1;
  logic                 s3InLast = 1'b0;
  logic                 s3InReady;
  logic [2:0]           s3OutValid;
  logic [2:0][1:0][7:0] s3OutData;
  logic [2:0][1:0]      s3OutKeep;
  logic [2:0]           s3OutLast;
  logic [2:0]           s3OutReady = '0;

`ifdef DATA_DEMULTIPLEXER_STATS_EN
  logic [3:0][31:0] pktCount;
  logic [31:0]      dropCount;
  logic [2:0][31:0] s3PktCount;
  logic [31:0]      s3DropCount;
`endif

  data_demultiplexer #(.data_t(logic [7:0]), .NUM_ELEMENTS(2), .NUM_STREAMS(4)) dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    .pkt_count_o    (pktCount),
    .drop_count_o   (dropCount),
`endif
    .select_valid_i (selValid),
    .select_data_i  (selData),
    .select_ready_o (selReady),
    .in_valid_i     (inValid),
    .in_data_i      (inData),
    .in_keep_i      (inKeep),
    .in_last_i      (inLast),
    .in_ready_o     (inReady),
    .out_valid_o    (outValid),
    .out_data_o     (outData),
    .out_keep_o     (outKeep),
    .out_last_o     (outLast),
    .out_ready_i    (outReady)
  );

  data_demultiplexer #(.data_t(logic [7:0]), .NUM_ELEMENTS(2), .NUM_STREAMS(3)) dut3 (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    .pkt_count_o    (s3PktCount),
    .drop_count_o   (s3DropCount),
`endif
    .select_valid_i (s3SelValid),
    .select_data_i  (s3SelData),
    .select_ready_o (s3SelReady),
    .in_valid_i     (s3InValid),
    .in_data_i      (s3InData),
    .in_keep_i      (s3InKeep),
    .in_last_i      (s3InLast),
    .in_ready_o     (s3InReady),
    .out_valid_o    (s3OutValid),
    .out_data_o     (s3OutData),
    .out_keep_o     (s3OutKeep),
    .out_last_o     (s3OutLast),
    .out_ready_i    (s3OutReady)
  );

  int   nCompared = 0;
  int   nMismatched = 0;
  int   vecIdx = -1;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, vecIdx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic sv, input logic [1:0] sd,
                              input logic iv, input logic [15:0] id, input logic [1:0] ik,
                              input logic il, input logic [3:0] ordy, input logic esr,
                              input logic eir, input logic [3:0] ev, input logic [15:0] ed,
                              input logic [1:0] ek, input logic el);
    vec_t v;
    v = '{r, sv, sd, iv, id, ik, il, ordy, esr, eir, ev, ed, ek, el};
    return v;
  endfunction

  // Drive on the falling edge, sample the combinational outputs 1 ns later.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n    = v.rstN;
    selValid = v.selValid;
    selData  = v.selData;
    inValid  = v.inValid;
    inData   = v.inData;
    inKeep   = v.inKeep;
    inLast   = v.inLast;
    outReady = v.outReady;
    #1;
    checkOutput("select_ready", 32'(selReady), 32'(v.expSelReady));
    checkOutput("in_ready", 32'(inReady), 32'(v.expInReady));
    checkOutput("out_valid", 32'(outValid), 32'(v.expValid));
    for (int k = 0; k < 4; k++) begin
      if (v.expValid[k]) begin
        checkOutput($sformatf("out%0d_data", k), 32'(outData[k]), 32'(v.expData));
        checkOutput($sformatf("out%0d_keep", k), 32'(outKeep[k]), 32'(v.expKeep));
        checkOutput($sformatf("out%0d_last", k), 32'(outLast[k]), 32'(v.expLast));
      end
    end
  endtask

  initial begin
    // rst, selV, selD, inV, inData, keep, last, outReady | selRdy, inRdy, valid, data, keep, last
    vecs.push_back(mk(1, 1, 2, 0, 16'h0000, 2'b11, 0, 4'hF, 1, 0, 4'b0000, 16'h0000, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000A, 2'b11, 0, 4'hF, 0, 1, 4'b0100, 16'h000A, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000B, 2'b11, 0, 4'hF, 0, 1, 4'b0100, 16'h000B, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000C, 2'b11, 1, 4'hF, 0, 1, 4'b0100, 16'h000C, 2'b11, 1));
    vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 2'b11, 0, 4'hF, 1, 0, 4'b0000, 16'h0000, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0011, 2'b11, 1, 4'hF, 0, 1, 4'b0010, 16'h0011, 2'b11, 1));
    vecs.push_back(mk(1, 1, 3, 1, 16'h0022, 2'b11, 1, 4'hF, 1, 0, 4'b0000, 16'h0000, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0022, 2'b11, 1, 4'hF, 0, 1, 4'b1000, 16'h0022, 2'b11, 1));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 2'b11, 0, 4'hF, 1, 0, 4'b0000, 16'h0000, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0001, 2'b11, 0, 4'hF, 0, 1, 4'b0001, 16'h0001, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0002, 2'b11, 0, 4'hE, 0, 0, 4'b0001, 16'h0002, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0002, 2'b11, 0, 4'hE, 0, 0, 4'b0001, 16'h0002, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0002, 2'b11, 0, 4'hF, 0, 1, 4'b0001, 16'h0002, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0003, 2'b11, 0, 4'hF, 0, 1, 4'b0001, 16'h0003, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0004, 2'b01, 1, 4'hF, 0, 1, 4'b0001, 16'h0004, 2'b01, 1));
    vecs.push_back(mk(1, 1, 2, 0, 16'h0000, 2'b11, 0, 4'hF, 1, 0, 4'b0000, 16'h0000, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0031, 2'b11, 0, 4'hF, 0, 1, 4'b0100, 16'h0031, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0032, 2'b11, 0, 4'hF, 0, 1, 4'b0100, 16'h0032, 2'b11, 0));
    vecs.push_back(mk(0, 1, 1, 1, 16'h0033, 2'b11, 0, 4'hF, 0, 0, 4'b0000, 16'h0000, 2'b00, 0));
    vecs.push_back(mk(1, 1, 1, 1, 16'h0033, 2'b11, 0, 4'hF, 1, 0, 4'b0000, 16'h0000, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0055, 2'b10, 1, 4'hF, 0, 1, 4'b0010, 16'h0055, 2'b10, 1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 2'b11, 0, 4'hF, 1, 0, 4'b0000, 16'h0000, 2'b00, 0));

    // Outputs held quiet during reset even with requests pending.
    selValid   = 1'b1;
    inValid    = 1'b1;
    s3SelValid = 1'b1;
    #3;
    checkOutput("reset select_ready", 32'(selReady), 32'd0);
    checkOutput("reset in_ready", 32'(inReady), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset s3 select_ready", 32'(s3SelReady), 32'd0);
    s3SelValid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vecIdx = i;
      applyStimulus(vecs[i]);
    end

`ifdef DATA_DEMULTIPLEXER_STATS_EN
    // Reset in the table cleared counters; only the 0x55 packet to out[1] follows it.
    checkOutput("pkt_count0", pktCount[0], 32'd0);
    checkOutput("pkt_count1", pktCount[1], 32'd1);
    checkOutput("pkt_count2", pktCount[2], 32'd0);
    checkOutput("pkt_count3", pktCount[3], 32'd0);
`endif

    // Out-of-range select on the 3-output instance: the packet is swallowed.
    vecIdx = 100;
    @(negedge clk);
    s3SelValid = 1'b1;
    s3SelData  = 2'd3;
    #1;
    checkOutput("drop select_ready", 32'(s3SelReady), 32'd1);
    @(negedge clk);
    s3SelValid = 1'b0;
    s3InValid  = 1'b1;
    s3InData   = 16'h0101;
    s3InLast   = 1'b0;
    #1;
    checkOutput("drop beat1 in_ready", 32'(s3InReady), 32'd1);
    checkOutput("drop beat1 out_valid", 32'(s3OutValid), 32'd0);
    checkOutput("drop beat1 select_ready", 32'(s3SelReady), 32'd0);
    @(negedge clk);
    s3InData = 16'h0102;
    s3InLast = 1'b1;
    #1;
    checkOutput("drop beat2 in_ready", 32'(s3InReady), 32'd1);
    checkOutput("drop beat2 out_valid", 32'(s3OutValid), 32'd0);
    @(negedge clk);
    s3InValid = 1'b0;
    s3InLast  = 1'b0;
    #1;
    checkOutput("drop back to idle select_ready", 32'(s3SelReady), 32'd1);
    checkOutput("drop idle in_ready", 32'(s3InReady), 32'd0);
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    checkOutput("drop_count", s3DropCount, 32'd1);
    checkOutput("s3 pkt_count0", s3PktCount[0], 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
